// File: rtl/divider_seq_if.sv
// Handshake and operand/result bundle for divider_seq.
// The master drives operands and start; the slave returns results and status.
interface divider_seq_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             data_signed;
   logic             data_start;
   logic [WIDTH-1:0] data_quotient;
   logic [WIDTH-1:0] data_remainder;
   logic             data_exception;
   logic             data_resultRDY;
   logic             data_busy;

   modport master (
      output data_operandA, data_operandB, data_signed, data_start,
      input  data_quotient, data_remainder, data_exception, data_resultRDY, data_busy
   );

   modport slave (
      input  data_operandA, data_operandB, data_signed, data_start,
      output data_quotient, data_remainder, data_exception, data_resultRDY, data_busy
   );
endinterface

// File: rtl/divider_seq.sv
// Sequential non-restoring divider, one quotient bit per clock, start/busy handshake.
// Define DIVIDER_SIGNED_EN to honour data_signed (two's-complement mode); otherwise all divisions are unsigned.
module divider_seq #(
   parameter int WIDTH = 32
) (
   input  logic          clock,
   input  logic          reset,
   divider_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state_reg;
   logic [WIDTH:0]   r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] a_reg;
   logic [CW-1:0]    count_reg;
   logic             zero_reg;
   logic [WIDTH-1:0] quot_reg;
   logic [WIDTH-1:0] rem_reg;
   logic             exc_reg;
   logic             rdy_reg;
   logic             busy_reg;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   r_step;
   logic [WIDTH-1:0] rem_mag;
   logic [WIDTH-1:0] quot_out;
   logic [WIDTH-1:0] rem_out;

`ifdef DIVIDER_SIGNED_EN
   logic a_neg;
   logic b_neg;
   logic neg_q_reg;
   logic neg_r_reg;

   assign a_neg = bus.data_signed & bus.data_operandA[WIDTH-1];
   assign b_neg = bus.data_signed & bus.data_operandB[WIDTH-1];
   assign abs_a = a_neg ? -bus.data_operandA : bus.data_operandA;
   assign abs_b = b_neg ? -bus.data_operandB : bus.data_operandB;
`else
   assign abs_a = bus.data_operandA;
   assign abs_b = bus.data_operandB;
`endif

   // Arithmetic is modulo 2^(WIDTH+1); the true partial remainder always lies in [-B, B).
   assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign r_step  = r_reg[WIDTH] ? (r_shift + {1'b0, b_reg}) : (r_shift - {1'b0, b_reg});
   assign rem_mag = r_reg[WIDTH] ? (r_reg[WIDTH-1:0] + b_reg) : r_reg[WIDTH-1:0];

`ifdef DIVIDER_SIGNED_EN
   // Most-negative / -1 falls out naturally: |A| = 2^(WIDTH-1) reinterpreted as the most-negative value.
   assign quot_out = neg_q_reg ? -q_reg : q_reg;
   assign rem_out  = neg_r_reg ? -rem_mag : rem_mag;
`else
   assign quot_out = q_reg;
   assign rem_out  = rem_mag;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         r_reg     <= '0;
         q_reg     <= '0;
         b_reg     <= '0;
         a_reg     <= '0;
         count_reg <= '0;
         zero_reg  <= 1'b0;
         quot_reg  <= '0;
         rem_reg   <= '0;
         exc_reg   <= 1'b0;
         rdy_reg   <= 1'b0;
         busy_reg  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
`endif
      end else begin
         rdy_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.data_start) begin
                  a_reg     <= bus.data_operandA;
                  b_reg     <= abs_b;
                  r_reg     <= '0;
                  q_reg     <= abs_a;
                  count_reg <= '0;
                  busy_reg  <= 1'b1;
                  zero_reg  <= (bus.data_operandB == '0);
`ifdef DIVIDER_SIGNED_EN
                  neg_q_reg <= a_neg ^ b_neg;
                  neg_r_reg <= a_neg;
`endif
                  state_reg <= (bus.data_operandB == '0) ? FIX : RUN;
               end
            end
            RUN: begin
               r_reg     <= r_step;
               q_reg     <= {q_reg[WIDTH-2:0], ~r_step[WIDTH]};
               count_reg <= count_reg + 1'b1;
               if (count_reg == LAST_STEP) begin
                  state_reg <= FIX;
               end
            end
            FIX: begin
               if (zero_reg) begin
                  quot_reg <= '0;
                  rem_reg  <= a_reg;
                  exc_reg  <= 1'b1;
               end else begin
                  quot_reg <= quot_out;
                  rem_reg  <= rem_out;
                  exc_reg  <= 1'b0;
               end
               rdy_reg   <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.data_quotient  = quot_reg;
   assign bus.data_remainder = rem_reg;
   assign bus.data_exception = exc_reg;
   assign bus.data_resultRDY = rdy_reg;
   assign bus.data_busy      = busy_reg;
endmodule

// File: tb/tb_divider_seq.sv
// Randomized scoreboard bench for divider_seq (WIDTH=32 and WIDTH=8 instances).
// Expected results come from plain arithmetic on the operands; monitors pop and compare on each result pulse.
module tb_divider_seq;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   divider_seq_if #(.WIDTH(W)) bus();
   divider_seq_if #(.WIDTH(8)) bus8();

   divider_seq #(.WIDTH(W)) dut  (.clock(clock), .reset(reset), .bus(bus));
   divider_seq #(.WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        exc;
      int          due;
      int          busy_len;
   } exp_t;

   exp_t sb[$];
   exp_t sb8[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int busy_run = 0;
   int busy_run8 = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      e.due = 0;
      if (b == 32'd0) begin
         e.q = 32'd0;
         e.r = a;
         e.exc = 1'b1;
         e.busy_len = 1;
      end else begin
         e.exc = 1'b0;
         e.busy_len = W + 1;
         e.q = a / b;
         e.r = a % b;
`ifdef DIVIDER_SIGNED_EN
         if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.q = 32'h8000_0000;
               e.r = 32'd0;
            end else begin
               e.q = $signed(a) / $signed(b);
               e.r = $signed(a) % $signed(b);
            end
         end
`else
         if (s) e.busy_len = W + 1;
`endif
      end
      return e;
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      int guard = 0;
      @(negedge clock);
      while (bus.data_busy && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout actual=busy required=idle within 200 cycles");
      end
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.data_signed   = s;
      bus.data_start    = 1'b1;
      e = model(a, b, s);
      e.due = cyc + 1 + e.busy_len;
      sb.push_back(e);
      $display("issue a=%08h b=%08h signed=%0d exp_q=%08h exp_r=%08h exp_exc=%0d", a, b, s, e.q, e.r, e.exc);
      @(negedge clock);
      bus.data_start = 1'b0;
   endtask

   // Drives a start with junk operands while the divider is busy; it must be ignored.
   task automatic poke_busy();
      @(negedge clock);
      if (bus.data_busy) begin
         bus.data_operandA = $urandom;
         bus.data_operandB = $urandom;
         bus.data_start    = 1'b1;
         @(negedge clock);
         bus.data_start    = 1'b0;
      end
   endtask

   always @(negedge clock) begin : monitor32
      exp_t e;
      if (reset) begin
         busy_run = 0;
      end else begin
         if (bus.data_busy) busy_run++;
         if (bus.data_resultRDY) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rdy actual=pulse required=none q=%08h", bus.data_quotient);
            end else begin
               e = sb.pop_front();
               $display("result q=%08h r=%08h exc=%0d cycle=%0d", bus.data_quotient, bus.data_remainder,
                        bus.data_exception, cyc);
               check("quotient", 64'(bus.data_quotient), 64'(e.q));
               check("remainder", 64'(bus.data_remainder), 64'(e.r));
               check("exception", 64'(bus.data_exception), 64'(e.exc));
               check("latency", 64'(cyc), 64'(e.due));
               check("busy_len", 64'(busy_run), 64'(e.busy_len));
            end
            busy_run = 0;
         end
      end
   end

   always @(negedge clock) begin : monitor8
      exp_t e;
      if (reset) begin
         busy_run8 = 0;
      end else begin
         if (bus8.data_busy) busy_run8++;
         if (bus8.data_resultRDY) begin
            if (sb8.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rdy8 actual=pulse required=none");
            end else begin
               e = sb8.pop_front();
               $display("result8 q=%02h r=%02h exc=%0d cycle=%0d", bus8.data_quotient, bus8.data_remainder,
                        bus8.data_exception, cyc);
               check("quotient8", 64'(bus8.data_quotient), 64'(e.q));
               check("remainder8", 64'(bus8.data_remainder), 64'(e.r));
               check("exception8", 64'(bus8.data_exception), 64'(e.exc));
               check("latency8", 64'(cyc), 64'(e.due));
               check("busy_len8", 64'(busy_run8), 64'(e.busy_len));
            end
            busy_run8 = 0;
         end
      end
   end

   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      bus8.data_operandA = a;
      bus8.data_operandB = b;
      bus8.data_signed   = 1'b0;
      bus8.data_start    = 1'b1;
      e.q = 32'(a / b);
      e.r = 32'(a % b);
      e.exc = 1'b0;
      e.busy_len = 9;
      e.due = cyc + 1 + 9;
      sb8.push_back(e);
      $display("issue8 a=%02h b=%02h exp_q=%02h exp_r=%02h", a, b, e.q[7:0], e.r[7:0]);
      @(negedge clock);
      bus8.data_start = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_quotient"}, 64'(bus.data_quotient), 64'd0);
      check({tag, "_remainder"}, 64'(bus.data_remainder), 64'd0);
      check({tag, "_exception"}, 64'(bus.data_exception), 64'd0);
      check({tag, "_rdy"}, 64'(bus.data_resultRDY), 64'd0);
      check({tag, "_busy"}, 64'(bus.data_busy), 64'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int guard;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.data_signed   = 1'b0;
      bus.data_start    = 1'b0;
      bus8.data_operandA = '0;
      bus8.data_operandB = '0;
      bus8.data_signed   = 1'b0;
      bus8.data_start    = 1'b0;
      repeat (3) @(negedge clock);
      check_zero_outputs("reset");
      reset = 1'b0;

      issue(32'd100, 32'd7, 1'b0);
      issue(32'hFFFF_FF9C, 32'd7, 1'b1);
      issue(32'd100, 32'hFFFF_FFF9, 1'b1);
      issue(32'd5, 32'd0, 1'b0);
      issue(32'd9, 32'd3, 1'b0);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(32'hFFFF_FFFF, 32'd1, 1'b0);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      issue(32'd0, 32'd5, 1'b1);
      issue(32'd7, 32'd100, 1'b0);
      issue(32'h8000_0000, 32'd0, 1'b1);
      poke_busy();

      for (int i = 0; i < 40; i++) begin
         int sel;
         sel = $urandom_range(0, 7);
         a = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
         case (sel)
            0:       b = 32'd0;
            1, 2, 3: b = $urandom_range(1, 15);
            7:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         issue(a, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) poke_busy();
      end

      // Abort mid-run: ignored start at ~cycle 10, reset at ~cycle 20, no pulse afterwards.
      guard = 0;
      while ((sb.size() != 0 || bus.data_busy) && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      issue(32'd1000, 32'd3, 1'b0);
      repeat (8) @(negedge clock);
      bus.data_operandA = 32'd77;
      bus.data_operandB = 32'd5;
      bus.data_start    = 1'b1;
      @(negedge clock);
      bus.data_start    = 1'b0;
      repeat (9) @(negedge clock);
      reset = 1'b1;
      sb.delete();
      #1;
      check_zero_outputs("abort");
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);
      issue(32'd1000, 32'd3, 1'b0);

      // WIDTH=8 instance: 255/16 then back-to-back 200/200 in the result cycle.
      @(negedge clock);
      issue8(8'd255, 8'd16);
      guard = 0;
      while (!bus8.data_resultRDY && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         failures++;
         $display("FAIL rdy8_timeout actual=no_pulse required=pulse");
      end
      issue8(8'd200, 8'd200);

      guard = 0;
      while ((sb.size() != 0 || sb8.size() != 0) && guard < 300) begin
         @(negedge clock);
         guard++;
      end
      checks++;
      if (sb.size() != 0 || sb8.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d_pending required=0", sb.size() + sb8.size());
      end
      repeat (3) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
